// File: rtl/logic_slice_sequencer_if.sv
// Handshake and result bus for the logic slice sequencer.
// The master presents operands; the slave walks them through a narrow slice.
interface logic_slice_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic [1:0]       ctrl_op;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_zero;
  logic             busy;

  modport master (
    output in_valid, operandA, operandB, ctrl_op,
    input  in_ready, result, result_valid, result_zero, busy
  );

  modport slave (
    input  in_valid, operandA, operandB, ctrl_op,
    output in_ready, result, result_valid, result_zero, busy
  );
endinterface

// File: rtl/logic_slice_sequencer.sv
// Drives one SLICE-wide bitwise logic slice across a WIDTH-bit operand pair,
// LSB chunk first, and assembles the result over NSLICE cycles.
module logic_slice_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  logic_slice_sequencer_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [1:0]       op_p0;
  logic [WIDTH-1:0] result_p1;
  logic [SLICE-1:0] chunk;
  logic             accept;

  function automatic logic [SLICE-1:0] slice_op(input logic [1:0]       op,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Count holds at LAST on the final chunk; only a new accept rewinds it.
  always_ff @(posedge clock) begin
    if (reset)                        count <= '0;
    else if (accept)                  count <= '0;
    else if (state == RUN && count != LAST) count <= count + 1'b1;
  end

  // Stage 0: operand capture at accept, held for the whole walk
  always_ff @(posedge clock) begin
    if (accept) begin
      a_p0  <= bus.operandA;
      b_p0  <= bus.operandB;
      op_p0 <= bus.ctrl_op;
    end
  end

  always_comb begin
    chunk = slice_op(op_p0,
                     a_p0[int'(count)*SLICE +: SLICE],
                     b_p0[int'(count)*SLICE +: SLICE]);
  end

  // Stage 1: result assembly; unwritten chunks stay zero until their turn
  always_ff @(posedge clock) begin
    if (reset)             result_p1 <= '0;
    else if (accept)       result_p1 <= '0;
    else if (state == RUN) result_p1[int'(count)*SLICE +: SLICE] <= chunk;
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.result       = result_p1;
  assign bus.result_valid = (state == DONE);
  assign bus.result_zero  = (state == DONE) && (result_p1 == '0);
endmodule
